// File: rtl/mips_pkg.sv
// Shared loader definitions: FSM state encoding and instruction word geometry.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        DONE_ST = 2'd2
    } ldr_state_t;

    // Bytes per instruction word, also the write address stride.
    localparam int unsigned INS_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles four little-endian stream bytes into one 32-bit word.
module byte_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic        word_vld,
    output logic [31:0] word
);

    logic [1:0] lane;

    // Right shift: after four accepts the first byte has landed in bits 7:0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane     <= '0;
            word     <= '0;
            word_vld <= 1'b0;
        end else begin
            word_vld <= 1'b0;
            if (clr) begin
                lane <= '0;
            end else if (accept) begin
                word     <= {byte_in, word[31:8]};
                lane     <= lane + 2'd1;
                word_vld <= (lane == 2'(INS_BYTES - 1));
            end
        end
    end

endmodule

// File: rtl/ins_mem_loader.sv
// Instruction memory loader: byte stream in, stride-4 word writes out.
// Optional running checksum of written words when CHECKSUM_EN is defined.
module ins_mem_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADR_W = 32,
    parameter int unsigned CNT_W = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [ADR_W-1:0] BASE_ADR,
    input  logic [CNT_W-1:0] WORD_CNT,
    input  logic             ABORT,
    input  logic [7:0]       BYTE_IN,
    input  logic             BYTE_VLD,
    output logic             BYTE_RDY,
    output logic             MEM_WRITE,
    output logic [ADR_W-1:0] WR_ADR,
    output logic [31:0]      WR_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic [31:0]      CHECKSUM
);

    ldr_state_t       state, state_nxt;
    logic [ADR_W-1:0] adr;
    logic [CNT_W-1:0] cnt;
    logic             word_vld;
    logic [31:0]      word;
    logic             start_ok;
    logic             last_word;
    logic             accept;

    assign start_ok  = START && !ABORT && (state == IDLE || state == DONE_ST);
    assign last_word = word_vld && (cnt == CNT_W'(1));
    // Hold off the stream while the final word is being written so no byte
    // beyond the image is swallowed.
    assign BYTE_RDY  = (state == LOAD) && !last_word;
    assign accept    = BYTE_VLD && BYTE_RDY;

    assign MEM_WRITE = word_vld;
    assign WR_DATA   = word;
    assign WR_ADR    = adr;
    assign BUSY      = (state == LOAD);
    assign DONE      = (state == DONE_ST);

    byte_packer u_packer (
        .clk      (CLK),
        .rst      (RST),
        .clr      (ABORT || start_ok),
        .accept   (accept),
        .byte_in  (BYTE_IN),
        .word_vld (word_vld),
        .word     (word)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ABORT) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE_ST: if (START) state_nxt = (WORD_CNT == '0) ? DONE_ST : LOAD;
                LOAD:          if (last_word) state_nxt = DONE_ST;
                default:       state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            adr <= '0;
            cnt <= '0;
        end else if (start_ok) begin
            adr <= BASE_ADR;
            cnt <= WORD_CNT;
        end else if (word_vld) begin
            adr <= adr + ADR_W'(INS_BYTES);
            cnt <= cnt - CNT_W'(1);
        end
    end

`ifdef CHECKSUM_EN
    logic [31:0] csum;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)           csum <= '0;
        else if (start_ok) csum <= '0;
        else if (word_vld) csum <= csum + word;
    end

    assign CHECKSUM = csum;
`else
    assign CHECKSUM = '0;
`endif

endmodule

// File: tb/tb_ins_mem_loader.sv
// Scoreboard bench for ins_mem_loader: expected writes queued per load, monitor pops on MEM_WRITE.
module tb_ins_mem_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [31:0] BASE_ADR = '0;
    logic [23:0] WORD_CNT = '0;
    logic        ABORT = 1'b0;
    logic [7:0]  BYTE_IN = '0;
    logic        BYTE_VLD = 1'b0;
    logic        BYTE_RDY, MEM_WRITE, BUSY, DONE;
    logic [31:0] WR_ADR, WR_DATA, CHECKSUM;

    ins_mem_loader #(.ADR_W(32), .CNT_W(24)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BASE_ADR(BASE_ADR), .WORD_CNT(WORD_CNT),
        .ABORT(ABORT), .BYTE_IN(BYTE_IN), .BYTE_VLD(BYTE_VLD), .BYTE_RDY(BYTE_RDY),
        .MEM_WRITE(MEM_WRITE), .WR_ADR(WR_ADR), .WR_DATA(WR_DATA), .BUSY(BUSY),
        .DONE(DONE), .CHECKSUM(CHECKSUM)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] wq[$];
    logic [7:0]  bq[$];
    logic [31:0] exp_csum = '0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] model_csum(input logic [31:0] s);
`ifdef CHECKSUM_EN
        return s;
`else
        return 32'h0 & s;
`endif
    endfunction

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge CLK) begin
        if (!RST && MEM_WRITE) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {WR_ADR, WR_DATA}, 64'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_adr", {32'h0, WR_ADR}, {32'h0, e.adr});
                check("wr_data", {32'h0, WR_DATA}, {32'h0, e.data});
            end
        end
    end

    // Expected writes for one image: word i at base + 4*i (mod 2^32).
    task automatic expect_words(input logic [31:0] base, input int unsigned n);
        wr_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.adr  = base + 32'(4 * i);
            e.data = wq[i];
            exp_q.push_back(e);
            exp_csum = exp_csum + wq[i];
        end
    endtask

    task automatic bytes_from_words(input int unsigned n);
        logic [31:0] w;
        bq.delete();
        for (int unsigned i = 0; i < n; i++) begin
            w = wq[i];
            for (int unsigned k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
        end
    endtask

    task automatic do_start(input logic [31:0] base, input logic [23:0] n);
        @(negedge CLK);
        START = 1'b1; BASE_ADR = base; WORD_CNT = n;
        @(negedge CLK);
        START = 1'b0; BASE_ADR = $urandom; WORD_CNT = 24'($urandom);
        exp_csum = '0;
        check("busy_after_start", {63'h0, BUSY}, {63'h0, (n != 0)});
        check("done_after_start", {63'h0, DONE}, {63'h0, (n == 0)});
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps.
    task automatic send_bytes(input int mode);
        int unsigned i = 0;
        int unsigned guard = 0;
        bit          on = 1'b1;
        while (i < bq.size() && guard < 400) begin
            @(negedge CLK);
            if (mode == 1) on = ~on;
            else if (mode == 2) on = ($urandom_range(0, 2) != 0);
            else on = 1'b1;
            if (on) begin
                BYTE_VLD = 1'b1;
                BYTE_IN  = bq[i];
                if (BYTE_RDY) i++;
            end else begin
                BYTE_VLD = 1'b0;
                BYTE_IN  = 8'($urandom);
            end
            guard++;
        end
        if (i < bq.size()) begin
            total_cnt++;
            $display("FAIL byte_timeout: sent %0d, expected %0d", i, bq.size());
        end
    endtask

    task automatic run_load(input logic [31:0] base, input int unsigned n, input int mode);
        do_start(base, 24'(n));
        expect_words(base, n);
        bytes_from_words(n);
        send_bytes(mode);
        @(negedge CLK);
        BYTE_VLD = 1'b0;
        check("last_wr_latency", {63'h0, MEM_WRITE}, 64'h1);
        check("busy_in_last_wr", {63'h0, BUSY}, 64'h1);
        @(negedge CLK);
        check("done_after_last", {63'h0, DONE}, 64'h1);
        check("busy_after_last", {63'h0, BUSY}, 64'h0);
        check("rdy_after_last", {63'h0, BYTE_RDY}, 64'h0);
        check("checksum", {32'h0, CHECKSUM}, {32'h0, model_csum(exp_csum)});
    endtask

    initial begin
        logic [31:0] r;
        // Reset values
        repeat (2) @(negedge CLK);
        check("rst_rdy", {63'h0, BYTE_RDY}, 64'h0);
        check("rst_wr", {63'h0, MEM_WRITE}, 64'h0);
        check("rst_busy_done", {62'h0, BUSY, DONE}, 64'h0);
        check("rst_adr_data", {WR_ADR, WR_DATA}, 64'h0);
        check("rst_csum", {32'h0, CHECKSUM}, 64'h0);
        RST = 1'b0;

        // Stream bytes while idle: must not be consumed.
        @(negedge CLK);
        BYTE_VLD = 1'b1; BYTE_IN = 8'hAA;
        check("idle_rdy", {63'h0, BYTE_RDY}, 64'h0);
        @(negedge CLK);
        BYTE_VLD = 1'b0;

        // Two words back-to-back.
        wq = '{32'h12345678, 32'hDEADBEEF};
        run_load(32'h100, 2, 0);

        // Zero-length image.
        do_start(32'h500, 24'd0);
        @(negedge CLK);
        check("zero_done_hold", {62'h0, DONE, BUSY}, 64'h2);

        // Valid toggling every other cycle.
        wq = '{32'h04030201};
        run_load(32'h40, 1, 1);

        // Abort after two bytes of a word, then reload from lane 0.
        do_start(32'h200, 24'd2);
        wq = '{32'h99887766};
        bytes_from_words(1);
        bq = bq[0:1];
        send_bytes(0);
        @(negedge CLK);
        BYTE_VLD = 1'b0; ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_state", {62'h0, BUSY, DONE}, 64'h0);
        wq = '{32'hCAFEF00D};
        run_load(32'h300, 1, 0);

        // Abort while a completed word is pending: that write still happens.
        do_start(32'h400, 24'd3);
        wq = '{32'h0BADC0DE};
        expect_words(32'h400, 1);
        bytes_from_words(1);
        send_bytes(0);
        @(negedge CLK);
        BYTE_VLD = 1'b0; ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_pending_state", {62'h0, BUSY, DONE}, 64'h0);
        check("abort_pending_csum", {32'h0, CHECKSUM}, {32'h0, model_csum(exp_csum)});

        // Address wrap.
        wq = '{32'hA5A5A5A5, 32'h5A5A5A5A};
        run_load(32'hFFFFFFFC, 2, 2);

        // Checksum overflow wraps mod 2^32, and holds in DONE_ST.
        wq = '{32'hFFFFFFFF, 32'h00000002};
        run_load(32'h800, 2, 0);
        repeat (3) @(negedge CLK);
        check("csum_hold", {32'h0, CHECKSUM}, {32'h0, model_csum(32'h1)});

        // Randomised images.
        for (int t = 0; t < 8; t++) begin
            int unsigned n;
            n = $urandom_range(1, 5);
            wq.delete();
            for (int unsigned i = 0; i < n; i++) wq.push_back($urandom);
            r = $urandom;
            run_load(r & 32'hFFFFFFFC, n, $urandom_range(0, 2));
        end

        repeat (4) @(negedge CLK);
        check("writes_outstanding", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
